// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Optional MIX_COLUMNS_BYPASS_EN adds in_bypass to pass a state through untransformed.
module mix_columns_engine #(
    parameter int NUM_COLS       = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*NUM_COLS-1:0] in_data,
    input  logic                  in_inv,
`ifdef MIX_COLUMNS_BYPASS_EN
    input  logic                  in_bypass,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*NUM_COLS-1:0] out_data,
    output logic                  busy
);

    localparam int W      = 32 * NUM_COLS;
    localparam int GW     = 32 * COLS_PER_CYCLE;
    localparam int GROUPS = NUM_COLS / COLS_PER_CYCLE;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

    generate
        if (!((COLS_PER_CYCLE == 1) || (COLS_PER_CYCLE == 2) || (COLS_PER_CYCLE == 4)) ||
            (NUM_COLS < 1) || ((NUM_COLS % COLS_PER_CYCLE) != 0)) begin : g_bad_cfg
            $error("mix_columns_engine: illegal NUM_COLS/COLS_PER_CYCLE combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // k is a 4-bit constant coefficient; product built from the x, 2x, 4x, 8x chain.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] m2, m4, m8;
        m2 = xtime(a);
        m4 = xtime(m2);
        m8 = xtime(m4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? m2 : 8'h00) ^
               (k[2] ? m4 : 8'h00) ^ (k[3] ? m8 : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  a [4];
        logic [3:0]  k [4];
        logic [7:0]  acc;
        logic [31:0] res;
        for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
        k[0] = inv ? 4'he : 4'h2;
        k[1] = inv ? 4'hb : 4'h3;
        k[2] = inv ? 4'hd : 4'h1;
        k[3] = inv ? 4'h9 : 4'h1;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc ^= gmul(a[(r+j)%4], k[j]);
            res[31-8*r -: 8] = acc;
        end
        return res;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     work_q, work_d;
    logic             inv_q, inv_d;
    logic             take_bypass;

`ifdef MIX_COLUMNS_BYPASS_EN
    assign take_bypass = in_bypass;
`else
    assign take_bypass = 1'b0;
`endif

    // Active column group is shifted to the top, transformed, then shifted back into place.
    int           shamt;
    logic [W-1:0] shifted, grp_ext, grp_mask, updated;
    logic [GW-1:0] grp_in, grp_out;

    always_comb begin
        shamt   = int'(cnt_q) * GW;
        shifted = work_q << shamt;
        grp_in  = shifted[W-1 -: GW];
        for (int c = 0; c < COLS_PER_CYCLE; c++)
            grp_out[GW-1-32*c -: 32] = mix_col(grp_in[GW-1-32*c -: 32], inv_q);
        grp_ext          = '0;
        grp_ext[W-1 -: GW] = grp_out;
        grp_mask = (~({W{1'b1}} >> GW)) >> shamt;
        updated  = (work_q & ~grp_mask) | (grp_ext >> shamt);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    inv_d   = in_inv;
                    cnt_d   = '0;
                    state_d = take_bypass ? DONE : BUSY;
                end
            end
            BUSY: begin
                work_d = updated;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_GRP) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        work_q <= work_d;
        inv_q  <= inv_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    // Gating keeps partial or discarded working state off the output bus.
    assign out_data  = (state_q == DONE) ? work_q : '0;

endmodule
